// File: rtl/spi_pkg.sv
// Shared constants, state encoding and helpers for the byte-wide SPI slave.
package spi_pkg;

  localparam int CP_CPOL = 1;
  localparam int CP_CPHA = 0;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE   = 1'b0;
  localparam state_t S_ACTIVE = 1'b1;

  // Shifted out on MISO when no byte was queued in time.
  localparam logic [7:0] SPI_TX_IDLE_FILL = 8'hFF;

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_byte_if.sv
// Byte hand-off between the SPI slave and the peripheral register/FIFO logic.
// TX: a byte transfers on any clk_i edge where tx_valid_i && tx_ready_o; RX: rx_valid_o is a
// one-cycle pulse with no back-pressure, and rx_data_o holds until the next pulse.
interface spi_slave_byte_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;

  modport slave  (input tx_data_i, tx_valid_i, output tx_ready_o, rx_data_o, rx_valid_o);
  modport master (output tx_data_i, tx_valid_i, input tx_ready_o, rx_data_o, rx_valid_o);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchronizer followed by one edge-detect flop; rise/fall are single-cycle pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_byte.sv
// Byte-wide SPI slave transceiver, all CPOL/CPHA modes, MSB/LSB first, oversampled by clk_i.
// Optional SPI_SLAVE_ABORT_FLAG_EN adds abort_o, pulsed when a byte is cut short by SS or en_i.
module spi_slave_byte
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] cp_mode_i,
  input  logic       msb_first_i,
  spi_slave_byte_if.slave host,
  output logic       tx_underrun_o,
  output logic       busy_o,
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  output logic       abort_o,
`endif
  input  logic       spi_clk_i,
  input  logic       spi_ss_i,
  input  logic       spi_dq0_i,
  output logic       spi_dq1_o,
  output logic       spi_dq1_oe_o
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d(spi_clk_i),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk_i(clk_i), .rst_i(rst_i), .d(spi_ss_i),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d(spi_dq0_i),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, ss_lvl, mosi_rise, mosi_fall};

  state_t     state;
  logic [7:0] hold_data;
  logic       hold_full;
  logic [6:0] tx_rest;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  logic       cpol, cpha;
  logic       lead_edge, trail_edge, sample_edge, drive_edge;
  logic       active, leave, start, run;
  logic       load_evt, shift_evt, samp_evt, tx_wr;
  logic [7:0] tx_load_val;
  logic [7:0] rx_next;

  assign cpol        = cp_mode_i[CP_CPOL];
  assign cpha        = cp_mode_i[CP_CPHA];
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge  : trail_edge;

  assign active = (state == S_ACTIVE);
  assign leave  = active && (ss_rise || !en_i);
  assign start  = !active && en_i && ss_fall;
  assign run    = active && !leave;

  // A byte begins on SS fall (CPHA=0) or on a drive edge with no bits counted yet; the
  // latter covers both the CPHA=1 first leading edge and the CPHA=0 post-byte trailing edge.
  assign load_evt  = (start && !cpha) || (run && drive_edge && (bit_cnt == 3'd0));
  assign shift_evt = run && drive_edge && (bit_cnt != 3'd0);
  assign samp_evt  = run && sample_edge;
  assign tx_wr     = host.tx_valid_i && !hold_full;

  assign tx_load_val = !hold_full  ? SPI_TX_IDLE_FILL :
                       msb_first_i ? hold_data : bit_rev8(hold_data);
  assign rx_next     = {rx_shift, mosi_lvl};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else if (start) begin
      state <= S_ACTIVE;
    end else if (leave) begin
      state <= S_IDLE;
    end
  end

  // Holding register: a same-cycle move only happens when full, a write only when empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_data <= 8'h00;
      hold_full <= 1'b0;
    end else begin
      if (load_evt && hold_full) hold_full <= 1'b0;
      if (tx_wr) begin
        hold_data <= host.tx_data_i;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_rest       <= 7'd0;
      spi_dq1_o     <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      tx_underrun_o <= 1'b0;
      if (load_evt) begin
        tx_rest       <= tx_load_val[6:0];
        spi_dq1_o     <= tx_load_val[7];
        tx_underrun_o <= !hold_full;
      end else if (shift_evt) begin
        tx_rest   <= {tx_rest[5:0], 1'b0};
        spi_dq1_o <= tx_rest[6];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_shift   <= 7'd0;
      bit_cnt    <= 3'd0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!run) begin
        rx_shift <= 7'd0;
        bit_cnt  <= 3'd0;
      end else if (samp_evt) begin
        rx_shift <= rx_next[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data_q  <= msb_first_i ? rx_next : bit_rev8(rx_next);
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_SLAVE_ABORT_FLAG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) abort_o <= 1'b0;
    else       abort_o <= leave && (bit_cnt != 3'd0);
  end
`endif

  assign host.tx_ready_o = !hold_full;
  assign host.rx_data_o  = rx_data_q;
  assign host.rx_valid_o = rx_valid_q;
  assign busy_o          = active;
  assign spi_dq1_oe_o    = active && en_i;

endmodule
